// File: rtl/fc_layer_sequencer_if.sv
// Handshake, weight-memory and ALU operand bundle of the fully-connected layer sequencer.
// master is the sequencer side; slave is the environment (source, weight RAM, MAC unit, sink).
interface fc_layer_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         w_rd_en;
  logic [7:0]   w_addr;
  logic [271:0] w_rdata;
  logic [255:0] alu_a;
  logic [255:0] alu_w;
  logic [15:0]  alu_bias;
  logic [16:0]  alu_result;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_data;
  logic         out_last;
  logic         busy;

  modport master (
    input  in_valid, in_data, w_rdata, alu_result, out_ready,
    output in_ready, w_rd_en, w_addr, alu_a, alu_w, alu_bias,
           out_valid, out_data, out_last, busy
  );

  modport slave (
    output in_valid, in_data, w_rdata, alu_result, out_ready,
    input  in_ready, w_rd_en, w_addr, alu_a, alu_w, alu_bias,
           out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer pass: load 16 activations, then per neuron fetch
// weights+bias, present them to an external MAC unit, saturate/ReLU the result and emit it.
module fc_layer_sequencer #(
  parameter int NUM_OUT = 10,
  parameter int RELU    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_layer_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    CAPTURE = 3'd3,
    EMIT    = 3'd4
  } state_t;

  state_t       state_reg, state_next;
  logic [7:0]   n_reg, n_next;
  logic [3:0]   slot_reg;
  logic [15:0]  act_reg [16];
  logic [15:0]  wgt_reg [16];
  logic [15:0]  bias_reg;
  logic [15:0]  out_data_reg;
  logic         out_last_reg;
  logic [255:0] alu_a_packed;
  logic [255:0] alu_w_packed;
  logic [15:0]  sat_data;
  logic [15:0]  post_data;
  logic         load_fire;
  logic         emit_fire;
  logic         n_is_last;

  assign load_fire = (state_reg == LOAD) && bus.in_valid;
  assign emit_fire = (state_reg == EMIT) && bus.out_ready;
  assign n_is_last = (n_reg == 8'(NUM_OUT - 1));

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    case (state_reg)
      LOAD:    if (load_fire && slot_reg == 4'd15) state_next = FETCH;
      FETCH:   state_next = LATCH;
      LATCH:   state_next = CAPTURE;
      CAPTURE: state_next = EMIT;
      EMIT: begin
        if (bus.out_ready) begin
          if (n_is_last) begin
            n_next     = '0;
            state_next = LOAD;
          end else begin
            n_next     = n_reg + 8'd1;
            state_next = FETCH;
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // 17-bit MAC result: the top two bits disagree only when it overflows 16 bits.
  always_comb begin
    sat_data  = bus.alu_result[15:0];
    if (!bus.alu_result[16] && bus.alu_result[15])
      sat_data = 16'h7fff;
    else if (bus.alu_result[16] && !bus.alu_result[15])
      sat_data = 16'h8000;
    post_data = sat_data;
    if (RELU != 0 && sat_data[15])
      post_data = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LOAD;
      n_reg        <= '0;
      slot_reg     <= '0;
      bias_reg     <= '0;
      out_data_reg <= '0;
      out_last_reg <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        act_reg[i] <= '0;
        wgt_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      if (load_fire) begin
        act_reg[slot_reg] <= bus.in_data;
        slot_reg          <= slot_reg + 4'd1;
      end
      if (state_reg == LATCH) begin
        for (int i = 0; i < 16; i++)
          wgt_reg[i] <= bus.w_rdata[i*16 +: 16];
        bias_reg <= bus.w_rdata[271:256];
      end
      if (state_reg == CAPTURE) begin
        out_data_reg <= post_data;
        out_last_reg <= n_is_last;
      end
      // Drop the last marker once consumed so it never outlives its result.
      if (emit_fire)
        out_last_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_pack
    assign alu_a_packed[gi*16 +: 16] = act_reg[gi];
    assign alu_w_packed[gi*16 +: 16] = wgt_reg[gi];
  end

  assign bus.alu_a     = alu_a_packed;
  assign bus.alu_w     = alu_w_packed;
  assign bus.alu_bias  = bias_reg;
  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.w_rd_en   = (state_reg == FETCH);
  assign bus.w_addr    = n_reg;
  assign bus.out_valid = (state_reg == EMIT);
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.busy      = (state_reg != LOAD);

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench: two sequencers (3 neurons with ReLU, 1 neuron linear) share one activation
// stream; each has its own weight-RAM and MAC stub, and results are checked against a queue.
module tb_fc_layer_sequencer;

  localparam int NA = 3;
  localparam int NB = 1;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        ready_a;
  logic        ready_b;
  int          n_cmp;
  int          n_err;
  int          cyc;

  int act [16];
  int wt  [3][16];
  int bs  [3];

  exp_t q_a[$];
  exp_t q_b[$];

  fc_layer_sequencer_if ifa ();
  fc_layer_sequencer_if ifb ();

  fc_layer_sequencer #(.NUM_OUT(NA), .RELU(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  fc_layer_sequencer #(.NUM_OUT(NB), .RELU(0)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ifa.in_valid  = in_valid;
  assign ifb.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifb.in_data   = in_data;
  assign ifa.out_ready = ready_a;
  assign ifb.out_ready = ready_b;

  function automatic logic [16:0] alu_model(input logic [255:0] a, input logic [255:0] w,
                                            input logic [15:0] b);
    int s;
    s = int'($signed(b));
    for (int k = 0; k < 16; k++)
      s += int'($signed(a[k*16 +: 16])) * int'($signed(w[k*16 +: 16]));
    return s[16:0];
  endfunction

  assign ifa.alu_result = alu_model(ifa.alu_a, ifa.alu_w, ifa.alu_bias);
  assign ifb.alu_result = alu_model(ifb.alu_a, ifb.alu_w, ifb.alu_bias);

  // Weight RAM: data valid for one cycle after the strobe, junk otherwise.
  function automatic logic [271:0] pack_w(input logic [7:0] a);
    logic [271:0] r;
    int idx;
    idx = int'(a);
    r = {17{16'hdead}};
    if (idx < 3) begin
      for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(wt[idx][k]);
      r[271:256] = 16'(bs[idx]);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    ifa.w_rdata <= ifa.w_rd_en ? pack_w(ifa.w_addr) : {17{16'hdead}};
    ifb.w_rdata <= ifb.w_rd_en ? pack_w(ifb.w_addr) : {17{16'hdead}};
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic int raw_of(input int n);
    int s;
    s = bs[n];
    for (int k = 0; k < 16; k++) s += act[k] * wt[n][k];
    return s;
  endfunction

  function automatic logic [15:0] post(input int raw, input bit relu);
    int v;
    v = raw;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return 16'(v);
  endfunction

  task automatic push_expected();
    exp_t e;
    for (int n = 0; n < NA; n++) begin
      e.data = post(raw_of(n), 1'b1);
      e.last = (n == NA - 1);
      q_a.push_back(e);
      $display("push a n=%0d raw=%0d data=%0h last=%0b", n, raw_of(n), e.data, e.last);
    end
    e.data = post(raw_of(0), 1'b0);
    e.last = 1'b1;
    q_b.push_back(e);
    $display("push b n=0 raw=%0d data=%0h last=1", raw_of(0), e.data);
  endtask

  task automatic clear_tables();
    for (int k = 0; k < 16; k++) begin
      act[k] = k + 1;
      for (int n = 0; n < 3; n++) wt[n][k] = 0;
    end
    for (int n = 0; n < 3; n++) bs[n] = 0;
  endtask

  task automatic random_tables();
    for (int k = 0; k < 16; k++) begin
      act[k] = int'($urandom_range(100)) - 50;
      for (int n = 0; n < 3; n++) wt[n][k] = int'($urandom_range(100)) - 50;
    end
    for (int n = 0; n < 3; n++) bs[n] = int'($urandom_range(2000)) - 1000;
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!(ifa.in_ready && ifb.in_ready) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_wait", {255'b0, ifa.in_ready & ifb.in_ready}, 256'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || !(ifa.in_ready && ifb.in_ready)) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_a", 256'(q_a.size()), 256'd0);
    chk("drain_b", 256'(q_b.size()), 256'd0);
    chk("idle_in_ready", {255'b0, ifa.in_ready & ifb.in_ready}, 256'd1);
  endtask

  task automatic wait_valid_a();
    int t;
    t = 0;
    while (!ifa.out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("a_valid_wait", {255'b0, ifa.out_valid}, 256'd1);
  endtask

  task automatic feed(input bit first);
    wait_ready();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(act[k]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (first) begin
      chk("a_in_ready_drop", {255'b0, ifa.in_ready}, 256'd0);
      chk("a_rd_en_first",   {255'b0, ifa.w_rd_en}, 256'd1);
      chk("a_addr_first",    {248'b0, ifa.w_addr}, 256'd0);
      chk("a_slot15",        {240'b0, ifa.alu_a[255:240]}, {240'b0, 16'(act[15])});
      chk("a_busy",          {255'b0, ifa.busy}, 256'd1);
    end
  endtask

  // Per-cycle monitor for both DUTs: address order, latency, spacing, stall stability, results.
  int          exp_addr   [2];
  int          rd_cyc     [2];
  int          stall_cnt  [2];
  bit          prev_vld   [2];
  bit          prev_stall [2];
  logic [15:0] prev_data  [2];
  logic        prev_last  [2];

  always @(negedge clk) begin : mon
    logic        vld, rdy, rd, last;
    logic [7:0]  addr;
    logic [15:0] data;
    exp_t        e;
    int          nmax;
    string       p;
    for (int d = 0; d < 2; d++) begin
      vld  = d ? ifb.out_valid : ifa.out_valid;
      rdy  = d ? ifb.out_ready : ifa.out_ready;
      rd   = d ? ifb.w_rd_en   : ifa.w_rd_en;
      addr = d ? ifb.w_addr    : ifa.w_addr;
      data = d ? ifb.out_data  : ifa.out_data;
      last = d ? ifb.out_last  : ifa.out_last;
      nmax = d ? NB : NA;
      p    = d ? "b" : "a";
      if (rst) begin
        exp_addr[d]   = 0;
        stall_cnt[d]  = 0;
        prev_vld[d]   = 1'b0;
        prev_stall[d] = 1'b0;
      end else begin
        if (rd) begin
          chk({p, "_addr"}, {248'b0, addr}, 256'(exp_addr[d]));
          if (exp_addr[d] != 0)
            chk({p, "_gap"}, 256'(cyc - rd_cyc[d]), 256'(4 + stall_cnt[d]));
          rd_cyc[d]    = cyc;
          stall_cnt[d] = 0;
          exp_addr[d]  = (exp_addr[d] == nmax - 1) ? 0 : exp_addr[d] + 1;
        end
        if (vld && !prev_vld[d])
          chk({p, "_latency"}, 256'(cyc - rd_cyc[d]), 256'd3);
        if (vld)
          chk({p, "_no_rd_in_emit"}, {255'b0, rd}, 256'd0);
        if (prev_stall[d]) begin
          chk({p, "_stall_valid"}, {255'b0, vld}, 256'd1);
          chk({p, "_stall_data"},  {240'b0, data}, {240'b0, prev_data[d]});
          chk({p, "_stall_last"},  {255'b0, last}, {255'b0, prev_last[d]});
        end
        if (vld && rdy) begin
          if ((d ? q_b.size() : q_a.size()) == 0) begin
            chk({p, "_unexpected_result"}, 256'd1, 256'd0);
          end else begin
            e = d ? q_b.pop_front() : q_a.pop_front();
            $display("result %s data=%0h last=%0b expected data=%0h last=%0b",
                     p, data, last, e.data, e.last);
            chk({p, "_data"}, {240'b0, data}, {240'b0, e.data});
            chk({p, "_last"}, {255'b0, last}, {255'b0, e.last});
          end
        end
        if (vld && !rdy) stall_cnt[d]++;
        prev_vld[d]   = vld;
        prev_stall[d] = vld && !rdy;
        prev_data[d]  = data;
        prev_last[d]  = last;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; ready_a = 1'b1; ready_b = 1'b1;
    clear_tables();
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", {255'b0, ifa.out_valid}, 256'd0);
    chk("rst_out_last",  {255'b0, ifa.out_last}, 256'd0);
    chk("rst_out_data",  {240'b0, ifa.out_data}, 256'd0);
    chk("rst_w_rd_en",   {255'b0, ifa.w_rd_en}, 256'd0);
    chk("rst_w_addr",    {248'b0, ifa.w_addr}, 256'd0);
    chk("rst_busy",      {255'b0, ifa.busy | ifb.busy}, 256'd0);
    chk("rst_alu_a",     ifa.alu_a, 256'd0);
    chk("rst_alu_w",     ifa.alu_w, 256'd0);
    chk("rst_alu_bias",  {240'b0, ifa.alu_bias}, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {255'b0, ifa.in_ready & ifb.in_ready}, 256'd1);

    // Pass 1: positive overflow, ReLU-clamped negative, small positive; stall A on first result.
    clear_tables();
    wt[0][15] = 2000;  bs[0] = 8000;
    wt[1][15] = -1000; bs[1] = -4000;
    wt[2][0]  = 5;     bs[2] = 100;
    push_expected();
    feed(1'b1);
    ready_a = 1'b0;
    wait_valid_a();
    repeat (5) @(posedge clk);
    #1;
    chk("a_held_valid", {255'b0, ifa.out_valid}, 256'd1);
    ready_a = 1'b1;
    drain();

    // Pass 2: negative overflow, small negative, positive sum of all slots.
    clear_tables();
    wt[0][15] = -2000; bs[0] = -8000;
    for (int k = 0; k < 16; k++) wt[1][k] = 1;
    bs[1] = -200;
    for (int k = 0; k < 16; k++) wt[2][k] = 100;
    bs[2] = 1000;
    push_expected();
    feed(1'b0);
    drain();

    // Pass 3: -20000 (linear passes it, ReLU clamps), mixed-sign weights, bias-driven underflow.
    clear_tables();
    wt[0][15] = -1000; bs[0] = -4000;
    for (int k = 0; k < 16; k++) wt[1][k] = k - 7;
    bs[1] = 50;
    wt[2][0] = 300; wt[2][1] = -200; bs[2] = -32768;
    push_expected();
    feed(1'b0);
    drain();

    for (int p = 0; p < 3; p++) begin
      random_tables();
      push_expected();
      feed(1'b0);
      drain();
    end

    // Reset while A waits in EMIT: the pending result must vanish.
    random_tables();
    push_expected();
    feed(1'b0);
    ready_a = 1'b0;
    wait_valid_a();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {255'b0, ifa.out_valid}, 256'd0);
    chk("rst_mid_busy",      {255'b0, ifa.busy}, 256'd0);
    chk("rst_mid_alu_a",     ifa.alu_a, 256'd0);
    q_a.delete();
    q_b.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ready_a = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_in_ready", {255'b0, ifa.in_ready}, 256'd1);

    random_tables();
    push_expected();
    feed(1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fc_layer_sequencer.md
FC_LAYER_SEQUENCER -- requirements
Module: fc_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_OUT, default 10: output neurons per layer pass, range 1..256.
REQ-002 SHALL have parameter RELU, default 1: 1 clamps negative results to 0, 0 passes them through.
REQ-003 SHALL have port clk  input  1  — the only clock, rising edge.
REQ-004 SHALL have port rst  input  1  — asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  — activation word valid.
REQ-006 SHALL have port in_ready  output  1  — sequencer accepts an activation this cycle.
REQ-007 SHALL have port in_data  input  16  — signed activation.
REQ-008 SHALL have port w_rd_en  output  1  — weight memory read strobe.
REQ-009 SHALL have port w_addr  output  8  — weight memory address, equal to the neuron index.
REQ-010 SHALL have port w_rdata  input  272  — read data, valid exactly 1 cycle after w_rd_en; weight k at [16k+15:16k] for k=0..15, bias at [271:256].
REQ-011 SHALL have port alu_a  output  256  — 16 signed activations; activation k at [16k+15:16k].
REQ-012 SHALL have port alu_w  output  256  — 16 signed weights, same packing as alu_a.
REQ-013 SHALL have port alu_bias  output  16  — signed bias.
REQ-014 SHALL have port alu_result  input  17  — signed result from the combinational 16-input MAC/truncate/bias unit.
REQ-015 SHALL have port out_valid  output  1  — result valid.
REQ-016 SHALL have port out_ready  input  1  — downstream accepts the result.
REQ-017 SHALL have port out_data  output  16  — signed saturated result.
REQ-018 SHALL have port out_last  output  1  — marks the neuron NUM_OUT-1 result.
REQ-019 SHALL have port busy  output  1  — high in any state other than LOAD.

Function
REQ-020 SHALL implement states LOAD, FETCH, LATCH, CAPTURE and EMIT.
REQ-021 In LOAD, SHALL assert in_ready and store in_data into activation slot k on each in_valid&in_ready, with k = 0..15 in arrival order.
REQ-022 SHALL go from LOAD to FETCH in the cycle after slot 15 is written, with neuron index n=0.
REQ-023 Outside LOAD, SHALL hold in_ready=0 and SHALL NOT alter activation registers.
REQ-024 In FETCH, SHALL assert w_rd_en for exactly one cycle with w_addr=n, then go to LATCH.
REQ-025 In LATCH, SHALL register w_rdata into the weight and bias registers, then go to CAPTURE.
REQ-026 alu_a, alu_w and alu_bias SHALL be driven directly from the registers, with no combinational path from w_rdata.
REQ-027 In CAPTURE, SHALL register the post-processed alu_result into out_data, then go to EMIT.
REQ-028 Post-processing SHALL saturate: alu_result > 32767 gives 32767; alu_result < -32768 gives -32768; otherwise the low 16 bits.
REQ-029 When RELU=1, post-processing SHALL then map any negative value to 0.
REQ-030 In EMIT, SHALL hold out_valid=1 and keep out_data and out_last stable until out_valid&out_ready.
REQ-031 out_last SHALL be 1 only when n = NUM_OUT-1.
REQ-032 On an EMIT handshake with n < NUM_OUT-1, SHALL increment n and go to FETCH.
REQ-033 On an EMIT handshake with n = NUM_OUT-1, SHALL clear n and go to LOAD.
REQ-034 Latency: out_valid SHALL rise exactly 3 cycles after the w_rd_en cycle; minimum throughput is 1 result per 4 cycles.
REQ-035 While out_ready is low, SHALL issue no w_rd_en and change no register other than the state hold.

Reset
REQ-036 On rst, asynchronously: state=LOAD, n=0, slot counter=0.
REQ-037 On rst, asynchronously: out_valid=0, out_last=0, out_data=0, w_rd_en=0, w_addr=0, busy=0.
REQ-038 On rst, asynchronously: activation, weight and bias registers=0, so alu_a=0, alu_w=0, alu_bias=0.
REQ-039 in_ready SHALL be 1 from the first clock edge after rst deasserts.
REQ-040 rst asserted in any state, including mid-EMIT, SHALL abort the pass; the pending result is discarded and never handshaken.

Verification
REQ-041 Feed 16 activations 1..16 with in_valid held high -> in_ready drops after the 16th; w_rd_en with w_addr=0 on the next cycle; alu_a slot 15 = 16.
REQ-042 Stub alu_result=40000 (NUM_OUT=1) -> out_data=32767, out_last=1; with alu_result=-40000 and RELU=0 -> out_data=-32768.
REQ-043 RELU=1 with alu_result=-20000 -> out_data=0; RELU=0 with the same stimulus -> out_data=-20000.
REQ-044 NUM_OUT=3 with out_ready tied high -> w_addr sequence 0,1,2, results 4 cycles apart, out_last only on the third result, then in_ready=1.
REQ-045 out_ready held low for 5 cycles in EMIT -> out_valid, out_data and out_last stable, no w_rd_en; the handshake completes when out_ready rises.
REQ-046 rst pulsed mid-EMIT -> out_valid=0 immediately; after release, in_ready=1 and the next w_rd_en carries w_addr=0.
